sat_gain_ctrl: RTL
==================

# sat_gain_ctrl

Frame-synchronous controller for the RGB saturation-adjust datapath. Converts two raw push-buttons (up/down) into a debounced gain index and a Q4.12 gain word for the saturation multipliers. Index changes are committed only at frame start (rising edge of `frame_vsync`), so one frame is never processed with mixed gains. Sits between board keys and the saturation block's `b` multiplier operand, in the pixel-clock domain.

## Interface
- `DEBOUNCE_CYC`, default 20'd1_000_000: stable-level cycles required to accept a key state (20 ms at 50 MHz).
- `IDX_MAX`, default 8'd50: highest gain index (gain 5.0).
- `IDX_RST`, default 8'd10: index after reset (gain 1.0).
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_up`  in  1  raw button, asynchronous, 1 = pressed.
- `key_dn`  in  1  raw button, asynchronous, 1 = pressed.
- `frame_vsync`  in  1  frame sync, synchronous to `clk`; a rising edge marks frame start.
- `gain_q12`  out  16  committed gain, unsigned Q4.12.
- `gain_idx`  out  8  committed index, 0..IDX_MAX.
- `gain_upd`  out  1  one-cycle pulse when `gain_q12` changes.
- `pending`  out  1  target index differs from committed index.

## Operation
- Each key passes through a 2-FF synchronizer and a debouncer. The debounce counter counts while the synced level differs from the stable level and clears otherwise. At `DEBOUNCE_CYC` the stable level toggles. A stable 0→1 transition is a press event: one-cycle pulse.
- Target index `tgt`: an up press gives `tgt+1`, saturating at IDX_MAX. A down press gives `tgt-1`, saturating at 0. There is no wrap.
- Up and down press pulses in the same cycle are both ignored.
- Gain mapping: gain(i) = floor((i·4096 + 5)/10). Examples: 0→0x0000, 4→0x0666, 10→0x1000, 11→0x119A, 50→0x5000.
- The mapping is a constant lookup over 0..255. Indices above IDX_MAX are unreachable.
- FSM `IDLE`: `tgt == gain_idx`. The next press moves to `PEND`.
- FSM `PEND`: `tgt != gain_idx`. Further presses only retarget `tgt`.
  - Frame start moves to `APPLY`.
  - If a press returns `tgt` to `gain_idx`, the FSM returns to `IDLE` without a commit.
- FSM `APPLY` (one cycle): commits the new `gain_idx`/`gain_q12` and pulses `gain_upd`. It then goes to `PEND` if `tgt != gain_idx` after the commit, else to `IDLE`.
- A press and frame start in the same cycle: the frame start commits the pre-press `tgt`. The new `tgt` is committed at the following frame start.
- A frame start while in `IDLE` produces no commit and no `gain_upd`.
- `pending` = (state != IDLE), registered.

## Timing
- Reset values: `gain_idx`=IDX_RST, `gain_q12`=gain(IDX_RST) (0x1000 for defaults), `gain_upd`=0, `pending`=0, `tgt`=IDX_RST, debouncers stable=0, FSM=`IDLE`.
- Press latency: the press pulse occurs 2 (sync) + DEBOUNCE_CYC + 1 cycles after the key rises. `pending` rises 1 cycle later.
- Frame-start detect: cycle N has `frame_vsync`=1 and registered `frame_vsync`=0.
- `gain_idx`, `gain_q12` and `gain_upd` all change on the clock edge ending cycle N+1, so they are valid from cycle N+2.
- `gain_q12` is registered, not combinational from `gain_idx`. It changes only together with `gain_upd`.
- Reset asserted mid-debounce or mid-`PEND`: everything returns to reset values immediately and the pending change is lost.

## Configuration
- `SAT_GAIN_RAMP_EN` defined: each commit moves `gain_idx` by one step toward `tgt`. `PEND` persists across frames until `tgt` is reached, so a jump of k indices takes k frames with k `gain_upd` pulses.
- Not defined: a commit loads `tgt` directly, one frame and one pulse per change.

## Structure
- Package `sat_pkg`:
  - `IDX_W`=8 and `GAIN_W`=16.
  - FSM state enum (`IDLE`, `PEND`, `APPLY`).
  - `gain_of(idx)` function / constant table producing Q4.12.
- Sub-module `key_debounce` (sync + counter + press pulse), instantiated twice, parameter `DEBOUNCE_CYC`.

## Test plan
- Reset release → `gain_idx`=10, `gain_q12`=0x1000, `pending`=0, `gain_upd`=0.
- Bench uses DEBOUNCE_CYC=16. Hold `key_up` 40 cycles, then pulse `frame_vsync` → `pending`=1 until the frame start. Then `gain_idx`=11, `gain_q12`=0x119A and one `gain_upd` pulse at N+2.
- Key glitch of 10 cycles (< DEBOUNCE_CYC) → no press, `pending` stays 0.
- 45 up presses from 10, then one frame start → `gain_idx`=50, `gain_q12`=0x5000.
- Down presses from 0 → `gain_idx` stays 0.
- Press `key_up` and `key_dn` simultaneously → no change to `tgt`. A press coincident with frame start → committed one frame later.
- Three up presses from 10, then three frame starts:
  - With `SAT_GAIN_RAMP_EN`: 0x119A, 0x1333, 0x14CD.
  - Without: 0x14CD after the first frame, no `gain_upd` on the later two.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types and the index-to-gain mapping for the saturation gain controller.
package sat_pkg;

  localparam int IDX_W  = 8;
  localparam int GAIN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Q4.12 gain for a tenth-step index, rounded to nearest: floor((i*4096 + 5) / 10).
  function automatic logic [GAIN_W-1:0] gain_of(input logic [IDX_W-1:0] idx);
    logic [31:0] num;
    num = ({{(32-IDX_W){1'b0}}, idx} << 12) + 32'd5;
    num = num / 32'd10;
    return num[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, level debouncer, one-cycle press pulse.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic        sync1, sync2;
  logic        stable, stable_d;
  logic [19:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours (the synchronizer relies on it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (sync2 != stable) begin
        if (cnt >= DEBOUNCE_CYC - 20'd1) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sat_gain_ctrl.sv
// Frame-synchronous gain controller: debounced up/down keys retarget an index that is
// committed at frame start. Define SAT_GAIN_RAMP_EN to step one index per frame.
module sat_gain_ctrl
  import sat_pkg::*;
#(
  parameter logic [19:0]      DEBOUNCE_CYC = 20'd1_000_000,
  parameter logic [IDX_W-1:0] IDX_MAX      = 8'd50,
  parameter logic [IDX_W-1:0] IDX_RST      = 8'd10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up,
  input  logic              key_dn,
  input  logic              frame_vsync,
  output logic [GAIN_W-1:0] gain_q12,
  output logic [IDX_W-1:0]  gain_idx,
  output logic              gain_upd,
  output logic              pending
);

  logic              up_p, dn_p;
  logic              up_ev, dn_ev, frame_start;
  logic              vsync_d;
  state_t            state_q, state_nx;
  logic [IDX_W-1:0]  tgt_q, tgt_nx;
  logic [IDX_W-1:0]  apply_q, apply_nx;
  logic [IDX_W-1:0]  idx_q, commit_idx;
  logic [GAIN_W-1:0] gain_q;
  logic              upd_q, pend_q;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_up),
    .press (up_p)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_dn),
    .press (dn_p)
  );

  assign frame_start = frame_vsync & ~vsync_d;
  assign up_ev       = up_p & ~dn_p;
  assign dn_ev       = dn_p & ~up_p;

  // apply_q holds the target captured at frame start, so a coincident press
  // only affects the following frame.
`ifdef SAT_GAIN_RAMP_EN
  always_comb begin
    commit_idx = idx_q;
    if (apply_q > idx_q)      commit_idx = idx_q + 8'd1;
    else if (apply_q < idx_q) commit_idx = idx_q - 8'd1;
  end
`else
  assign commit_idx = apply_q;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    tgt_nx   = tgt_q;
    apply_nx = apply_q;
    state_nx = state_q;

    if (up_ev && tgt_q < IDX_MAX)      tgt_nx = tgt_q + 8'd1;
    else if (dn_ev && tgt_q != '0)     tgt_nx = tgt_q - 8'd1;

    case (state_q)
      IDLE: begin
        if (tgt_nx != idx_q) state_nx = PEND;
      end
      PEND: begin
        if (frame_start) begin
          state_nx = APPLY;
          apply_nx = tgt_q;
        end else if (tgt_nx == idx_q) begin
          state_nx = IDLE;
        end
      end
      APPLY: begin
        state_nx = (tgt_nx != commit_idx) ? PEND : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= IDX_RST;
      apply_q <= IDX_RST;
      idx_q   <= IDX_RST;
      gain_q  <= gain_of(IDX_RST);
      upd_q   <= 1'b0;
      pend_q  <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      state_q <= state_nx;
      tgt_q   <= tgt_nx;
      apply_q <= apply_nx;
      vsync_d <= frame_vsync;
      pend_q  <= (state_nx != IDLE);
      upd_q   <= (state_q == APPLY);
      if (state_q == APPLY) begin
        idx_q  <= commit_idx;
        gain_q <= gain_of(commit_idx);
      end
    end
  end

  assign gain_q12 = gain_q;
  assign gain_idx = idx_q;
  assign gain_upd = upd_q;
  assign pending  = pend_q;

endmodule
